// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth table scanner: FSM state encoding,
// vector/table widths, the default expected table and a counter-width helper.
package scanner_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } scan_state_t;

    localparam int VEC_W   = 4;
    localparam int TABLE_W = 16;

    // w = ~(d ? a&b : c), bit i = w for vector i = {a,b,c,d}
    localparam logic [TABLE_W-1:0] E3_TABLE = 16'h1BBB;

    // Bits needed to hold SETTLE_CYCLES-1; never less than one bit.
    function automatic int cnt_width(input int settle);
        return (settle > 1) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// Scanner bus: start request and network output in, stimulus vector,
// status and captured table out. master = stimulus side, slave = scanner.
interface truth_table_scanner_if;
    import scanner_pkg::*;

    logic                 start;
    logic                 w_in;
    logic [VEC_W-1:0]     vec_out;
    logic                 busy;
    logic                 done;
    logic [TABLE_W-1:0]   table_out;
    logic                 match;

    modport master (
        output start, w_in,
        input  vec_out, busy, done, table_out, match
    );

    modport slave (
        input  start, w_in,
        output vec_out, busy, done, table_out, match
    );

endinterface

// File: rtl/truth_table_scanner_settle_counter.sv
// Loadable settle-time down-counter. Counts toward zero while enabled and
// then holds; zero flags the end of the settle window.
module settle_counter
    import scanner_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = cnt_width(SETTLE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: load wins, otherwise decrement until zero is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Truth table scanner: walks {a,b,c,d} through 0..15, waits SETTLE_CYCLES
// per vector for the gate network to resolve, samples w and builds a
// 16-bit table. Build option SCANNER_COMPARE_EN adds the EXPECTED
// comparator and the match register; without it match is tied low.
module truth_table_scanner
    import scanner_pkg::*;
#(
    parameter int                 SETTLE_CYCLES = 4,
    parameter logic [TABLE_W-1:0] EXPECTED      = E3_TABLE
) (
    input  logic                 clk,
    input  logic                 rst,
    truth_table_scanner_if.slave bus
);

    localparam int               CNT_W    = cnt_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(TABLE_W - 1);

    scan_state_t          state_q, state_d;
    logic [VEC_W-1:0]     vec_q, vec_d;
    logic [TABLE_W-1:0]   table_q, table_d;
    logic                 cnt_load;
    logic                 cnt_en;
    logic                 cnt_zero;
    logic                 scan_accept;
    logic                 sample_last;

    settle_counter #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (LOAD_VAL),
        .zero     (cnt_zero)
    );

    // FSM next state, vector stepping and table capture.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        table_d     = table_q;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        scan_accept = 1'b0;
        sample_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    scan_accept = 1'b1;
                    vec_d       = '0;
                    table_d     = '0;
                    cnt_load    = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                table_d[vec_q] = bus.w_in;
                if (vec_q == LAST_VEC) begin
                    sample_last = 1'b1;
                    state_d     = DONE;
                end else begin
                    vec_d    = vec_q + VEC_W'(1);
                    cnt_load = 1'b1;
                    state_d  = WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, vector and table registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            table_q <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            table_q <= table_d;
        end
    end

    assign bus.vec_out   = vec_q;
    assign bus.table_out = table_q;
    assign bus.busy      = (state_q == WAIT) || (state_q == SAMPLE);
    assign bus.done      = (state_q == DONE);

`ifdef SCANNER_COMPARE_EN
    logic match_q, match_d;

    // Compare the final table as it is completed, so match is already
    // valid in the DONE cycle alongside the done pulse.
    always_comb begin
        match_d = match_q;
        if (scan_accept) begin
            match_d = 1'b0;
        end else if (sample_last) begin
            match_d = (table_d == EXPECTED);
        end
    end

    // Match register, cleared on reset and on each accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign bus.match = match_q;
`else
    logic unused_cmp;
    assign unused_cmp = ^{EXPECTED, scan_accept, sample_last};
    assign bus.match  = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: two scanners (SETTLE_CYCLES 4 and 1) share
// start/rst. The 4-cycle one sees an ideal network, the 1-cycle one sees a
// network whose output lags vec_out by one cycle. A cycle-count model of the
// scan predicts every output each cycle; literal checks pin the model.
module tb_truth_table_scanner;
    import scanner_pkg::*;

    localparam int NI = 2;
`ifdef SCANNER_COMPARE_EN
    localparam bit CMP = 1'b1;
`else
    localparam bit CMP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic fault = 1'b0;

    always #5 clk = ~clk;

    logic [NI-1:0][3:0]  vec_o;
    logic [NI-1:0]       busy_o;
    logic [NI-1:0]       done_o;
    logic [NI-1:0]       match_o;
    logic [NI-1:0][15:0] tbl_o;

    int checks = 0;
    int errors = 0;

    function automatic int settle_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int scan_len(input int i);
        return 16 * (settle_of(i) + 1);
    endfunction

    // Network under scan: w = ~(d ? a&b : c), optional stuck-at-1 on vector 13.
    function automatic logic golden_w(input logic [3:0] v, input logic flt);
        logic a, b, c, d;
        a = v[3]; b = v[2]; c = v[1]; d = v[0];
        if (flt && v == 4'd13) return 1'b1;
        return !(d ? (a && b) : c);
    endfunction

    function automatic logic [15:0] golden_tbl(input logic flt);
        logic [15:0] t;
        for (int v = 0; v < 16; v++) t[v] = golden_w(4'(v), flt);
        return t;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int S = (g == 0) ? 4 : 1;
        truth_table_scanner_if bus();
        logic w_dly = 1'b0;

        truth_table_scanner #(
            .SETTLE_CYCLES (S),
            .EXPECTED      (E3_TABLE)
        ) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        always @(posedge clk) w_dly <= golden_w(bus.vec_out, fault);

        assign bus.start   = start;
        assign bus.w_in    = (g == 0) ? golden_w(bus.vec_out, fault) : w_dly;
        assign vec_o[g]    = bus.vec_out;
        assign busy_o[g]   = bus.busy;
        assign done_o[g]   = bus.done;
        assign match_o[g]  = bus.match;
        assign tbl_o[g]    = bus.table_out;
    end

    // Model: k = cycles since the accepting edge (0 = idle, N+1 = done cycle).
    int          k    [NI];
    int          acc  [NI];
    logic [3:0]  hvec [NI];
    logic [15:0] htbl [NI];
    logic        hmat [NI];
    int          cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                k[i] <= 0; hvec[i] <= 4'd0; htbl[i] <= 16'd0; hmat[i] <= 1'b0;
            end else if (k[i] == 0) begin
                if (start) begin
                    k[i] <= 1; acc[i] <= cyc;
                    hvec[i] <= 4'd0; htbl[i] <= 16'd0; hmat[i] <= 1'b0;
                end
            end else if (k[i] == scan_len(i) + 1) begin
                k[i] <= 0;
            end else begin
                k[i] <= k[i] + 1;
                if (k[i] == scan_len(i)) begin
                    hvec[i] <= 4'd15;
                    htbl[i] <= golden_tbl(fault);
                    hmat[i] <= CMP && (golden_tbl(fault) == E3_TABLE);
                end
            end
        end
    end

    int done_rel [NI];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // One cycle: step to the falling edge and compare every output.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            int          s, n;
            logic        eb;
            logic [15:0] m;
            s  = settle_of(i);
            n  = scan_len(i);
            eb = (k[i] >= 1) && (k[i] <= n);
            m  = '0;
            for (int v = 0; v < 16; v++) if ((v + 1) * (s + 1) < k[i]) m[v] = 1'b1;
            check($sformatf("busy%0d", i), busy_o[i], eb);
            check($sformatf("done%0d", i), done_o[i], k[i] == n + 1);
            check($sformatf("vec%0d", i), vec_o[i], eb ? 4'((k[i] - 1) / (s + 1)) : hvec[i]);
            check($sformatf("tbl%0d", i), tbl_o[i], eb ? (golden_tbl(fault) & m) : htbl[i]);
            check($sformatf("match%0d", i), match_o[i], eb ? 1'b0 : hmat[i]);
            if (done_o[i]) done_rel[i] = cyc - acc[i];
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        do begin
            tick();
            n++;
        end while (((busy_o | done_o) != '0) && n < max);
        check("idle_timeout", {busy_o, done_o}, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        check("rst_vec", vec_o[0], 0);
        check("rst_tbl", tbl_o[0], 0);
        check("rst_busy", busy_o, 0);
        tick();

        // Golden scan with a start pulse during busy that must be ignored
        done_rel = '{0, 0};
        pulse_start();
        repeat (9) tick();
        pulse_start();
        wait_idle(300);
        check("done_cyc_s4", done_rel[0], 81);
        check("done_cyc_s1", done_rel[1], 33);
        check("gold_tbl_s4", tbl_o[0], 16'h1BBB);
        check("gold_tbl_s1", tbl_o[1], 16'h1BBB);
        check("gold_match", match_o[0], CMP);
        check("hold_vec", vec_o[0], 15);

        // Fault on vector 13
        fault = 1'b1;
        tick();
        pulse_start();
        wait_idle(300);
        check("fault_tbl_s4", tbl_o[0], 16'h3BBB);
        check("fault_tbl_s1", tbl_o[1], 16'h3BBB);
        check("fault_match", match_o[0], 0);
        fault = 1'b0;
        tick();

        // Reset during vector 7
        pulse_start();
        for (int n = 0; n < 100 && vec_o[0] != 4'd7; n++) tick();
        check("reach_vec7", vec_o[0], 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_vec", vec_o[0], 0);
        check("midrst_tbl", tbl_o[0], 0);
        check("midrst_stat", {busy_o[0], done_o[0], match_o[0]}, 0);
        done_rel = '{0, 0};
        pulse_start();
        wait_idle(300);
        check("rescan_cyc", done_rel[0], 81);
        check("rescan_tbl", tbl_o[0], 16'h1BBB);

        // start coincident with reset
        rst = 1'b1;
        start = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        check("rst_start_busy", busy_o, 0);
        tick();
        check("rst_start_busy2", busy_o, 0);

        // start held high: back-to-back scans
        start = 1'b1;
        for (int n = 0; n < 200 && !done_o[0]; n++) tick();
        check("b2b_done", done_o[0], 1);
        tick();
        check("b2b_idle_busy", busy_o[0], 0);
        check("b2b_idle_tbl", tbl_o[0], 16'h1BBB);
        tick();
        check("b2b_rescan_busy", busy_o[0], 1);
        check("b2b_rescan_tbl", tbl_o[0], 0);
        start = 1'b0;
        wait_idle(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
